// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter feeding one uart_tx byte stream
// Whole packets are granted atomically; a single output register decouples uart_tx backpressure.
module uart_tx_arbiter #(
  parameter int N_REQ      = 3,
  parameter int GAP_CYCLES = 4,
  parameter int MAX_BYTES  = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_data_valid,
  input  logic                 tx_data_ready,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 overrun
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0]       MAX_CNT  = 8'(MAX_BYTES);
  localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [7:0]       byte_cnt, byte_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [7:0]       tx_data_nxt;
  logic             tx_valid_nxt;
  logic             overrun_nxt;

  logic             out_free;
  logic             out_xfer;
  logic             in_xfer;
  logic [7:0]       own_data;
  logic             own_last;
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;

  // The output register may reload in the same cycle it is emptied by uart_tx.
  assign out_free  = !tx_data_valid || tx_data_ready;
  assign out_xfer  = tx_data_valid && tx_data_ready;
  assign req_ready = ((state == XFER) && out_free) ? grant : '0;
  assign in_xfer   = |(req_valid & req_ready);
  assign busy      = (state != IDLE);

  always_comb begin
    own_data = '0;
    own_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == PTR_W'(i)) begin
        own_data = req_data[8*i +: 8];
        own_last = req_last[i];
      end
    end
  end

  // Two passes: indices at/after rr_ptr first, then wrap to the lowest index.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && req_valid[i] && (PTR_W'(i) >= rr_ptr)) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && req_valid[i]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      pick_onehot[i] = (pick_idx == PTR_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    grant_nxt    = grant;
    byte_cnt_nxt = byte_cnt;
    gap_cnt_nxt  = gap_cnt;
    overrun_nxt  = 1'b0;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_data_valid;

    if (in_xfer) begin
      tx_data_nxt  = own_data;
      tx_valid_nxt = 1'b1;
    end else if (out_xfer) begin
      tx_valid_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt    = XFER;
          owner_nxt    = pick_idx;
          grant_nxt    = pick_onehot;
          rr_ptr_nxt   = (pick_idx == PTR_TOP) ? '0 : pick_idx + 1'b1;
          byte_cnt_nxt = '0;
        end
      end
      XFER: begin
        if (in_xfer) begin
          byte_cnt_nxt = byte_cnt + 8'd1;
          if (own_last) begin
            state_nxt = DRAIN;
          end else if (byte_cnt + 8'd1 == MAX_CNT) begin
            state_nxt   = DRAIN;
            overrun_nxt = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!tx_data_valid) begin
          grant_nxt   = '0;
          gap_cnt_nxt = '0;
          state_nxt   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr        <= '0;
      owner         <= '0;
      grant         <= '0;
      byte_cnt      <= '0;
      gap_cnt       <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rr_ptr        <= rr_ptr_nxt;
      owner         <= owner_nxt;
      grant         <= grant_nxt;
      byte_cnt      <= byte_cnt_nxt;
      gap_cnt       <= gap_cnt_nxt;
      tx_data       <= tx_data_nxt;
      tx_data_valid <= tx_valid_nxt;
      overrun       <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vector table plus packet sequences for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset_n;
  logic        use4;
  logic [2:0]  req_valid;
  logic [2:0]  req_last;
  logic [23:0] req_data;
  logic        tx_data_ready;

  logic [2:0]  g64, r64, g4, r4;
  logic [7:0]  d64, d4;
  logic        v64, v4, b64, b4, o64, o4;

  logic [2:0]  grant, req_ready;
  logic [7:0]  tx_data;
  logic        tx_data_valid, busy, overrun;

  assign grant         = use4 ? g4 : g64;
  assign req_ready     = use4 ? r4 : r64;
  assign tx_data       = use4 ? d4 : d64;
  assign tx_data_valid = use4 ? v4 : v64;
  assign busy          = use4 ? b4 : b64;
  assign overrun       = use4 ? o4 : o64;

  uart_tx_arbiter #(.N_REQ(3), .GAP_CYCLES(4), .MAX_BYTES(64)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(r64), .tx_data(d64), .tx_data_valid(v64),
    .tx_data_ready(tx_data_ready), .grant(g64), .busy(b64), .overrun(o64));

  uart_tx_arbiter #(.N_REQ(3), .GAP_CYCLES(4), .MAX_BYTES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(r4), .tx_data(d4), .tx_data_valid(v4),
    .tx_data_ready(tx_data_ready), .grant(g4), .busy(b4), .overrun(o4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  last;
    logic [23:0] data;
    logic        txr;
    logic [2:0]  e_grant;
    logic [2:0]  e_ready;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic        e_busy;
  } vec_t;

  int          checks;
  int          errors;
  logic [8:0]  pq[3][$];
  logic [7:0]  out_q[$];
  logic [7:0]  exp_q[$];
  logic [2:0]  glog[$];
  logic [2:0]  prev_grant;
  logic        prev_stall;
  logic [7:0]  prev_txd;
  int          ready_err, stab_err, ov_cnt, stall_at, stall_left, stall_seen;

  function automatic vec_t mk(input logic [2:0] v, input logic [2:0] l, input logic [23:0] d,
                              input logic t, input logic [2:0] g, input logic [2:0] r,
                              input logic tv, input logic [7:0] td, input logic b);
    vec_t x;
    x.valid = v; x.last = l; x.data = d; x.txr = t;
    x.e_grant = g; x.e_ready = r; x.e_txv = tv; x.e_txd = td; x.e_busy = b;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_state();
    for (int i = 0; i < 3; i++) pq[i].delete();
    out_q.delete();
    exp_q.delete();
    glog.delete();
    prev_grant = '0; prev_stall = 1'b0; prev_txd = '0;
    ready_err = 0; stab_err = 0; ov_cnt = 0;
    stall_at = -1; stall_left = 0; stall_seen = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; tx_data_ready = 1'b1;
    clear_state();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock: requesters present their queue heads, transfers due at the next edge are recorded.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (pq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = pq[i][0][7:0];
        req_last[i] = pq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = '0;
        req_last[i] = 1'b0;
      end
    end
    if (stall_left > 0 && tx_data_valid && out_q.size() == stall_at) begin
      tx_data_ready = 1'b0;
      stall_left--;
      stall_seen++;
    end else begin
      tx_data_ready = 1'b1;
    end
    #1;
    if ((req_ready & ~grant) != 3'b000) ready_err++;
    if (tx_data_valid && !tx_data_ready && req_ready != 3'b000) ready_err++;
    if (prev_stall && (tx_data !== prev_txd || tx_data_valid !== 1'b1)) stab_err++;
    prev_stall = tx_data_valid && !tx_data_ready;
    prev_txd   = tx_data;
    if (grant != 3'b000 && prev_grant == 3'b000) glog.push_back(grant);
    prev_grant = grant;
    if (overrun) ov_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (req_valid[i] && req_ready[i]) void'(pq[i].pop_front());
    end
    if (tx_data_valid && tx_data_ready) out_q.push_back(tx_data);
  endtask

  task automatic run_out(input int n, input int budget);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
  endtask

  task automatic run_idle(input string name, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      cycle();
      k++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_out(input string name);
    chk($sformatf("%s_len", name), out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", name, i),
          (i < out_q.size()) ? {24'd0, out_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_grant"}, {29'd0, grant}, 32'd0);
    chk({name, "_ready"}, {29'd0, req_ready}, 32'd0);
    chk({name, "_txd"}, {24'd0, tx_data}, 32'd0);
    chk({name, "_txv"}, {31'd0, tx_data_valid}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t  vecs[$];
    string msg;
    int    first_g, first_v, first_r, gap_len, k;
    bit    pushed, seen_idle, idle_before, got2;
    int    viol2;

    checks = 0; errors = 0;
    use4 = 1'b0;
    reset_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; tx_data_ready = 1'b1;
    clear_state();

    // Cycle table: requester 1 sends 55,AA; 0 and 2 request during GAP; rr_ptr=2 picks 2.
    vecs.push_back(mk(3'b010, 3'b000, 24'h005500, 1, 3'b000, 3'b000, 0, 8'h00, 0));
    vecs.push_back(mk(3'b010, 3'b000, 24'h005500, 1, 3'b010, 3'b010, 0, 8'h00, 1));
    vecs.push_back(mk(3'b010, 3'b010, 24'h00AA00, 1, 3'b010, 3'b010, 1, 8'h55, 1));
    vecs.push_back(mk(3'b000, 3'b000, 24'h000000, 1, 3'b010, 3'b000, 1, 8'hAA, 1));
    vecs.push_back(mk(3'b000, 3'b000, 24'h000000, 1, 3'b010, 3'b000, 0, 8'hAA, 1));
    vecs.push_back(mk(3'b101, 3'b000, 24'h000000, 1, 3'b000, 3'b000, 0, 8'hAA, 1));
    vecs.push_back(mk(3'b101, 3'b000, 24'h000000, 1, 3'b000, 3'b000, 0, 8'hAA, 1));
    vecs.push_back(mk(3'b101, 3'b000, 24'h000000, 1, 3'b000, 3'b000, 0, 8'hAA, 1));
    vecs.push_back(mk(3'b101, 3'b000, 24'h000000, 1, 3'b000, 3'b000, 0, 8'hAA, 1));
    vecs.push_back(mk(3'b101, 3'b100, 24'h330000, 1, 3'b000, 3'b000, 0, 8'hAA, 0));
    vecs.push_back(mk(3'b101, 3'b100, 24'h330000, 1, 3'b100, 3'b100, 0, 8'hAA, 1));
    vecs.push_back(mk(3'b001, 3'b000, 24'h000000, 1, 3'b100, 3'b000, 1, 8'h33, 1));
    vecs.push_back(mk(3'b001, 3'b000, 24'h000000, 1, 3'b100, 3'b000, 0, 8'h33, 1));

    do_reset();
    #1;
    check_reset_outputs("reset");
    foreach (vecs[i]) begin
      @(negedge clk);
      req_valid = vecs[i].valid;
      req_last = vecs[i].last;
      req_data = vecs[i].data;
      tx_data_ready = vecs[i].txr;
      #1;
      chk($sformatf("vec%0d_grant", i), {29'd0, grant}, {29'd0, vecs[i].e_grant});
      chk($sformatf("vec%0d_ready", i), {29'd0, req_ready}, {29'd0, vecs[i].e_ready});
      chk($sformatf("vec%0d_txv", i), {31'd0, tx_data_valid}, {31'd0, vecs[i].e_txv});
      chk($sformatf("vec%0d_txd", i), {24'd0, tx_data}, {24'd0, vecs[i].e_txd});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
    end

    // AT command from requester 0, latency and GAP length.
    do_reset();
    msg = "AT+CWMODE=1\r\n";
    for (int i = 0; i < msg.len(); i++) begin
      pq[0].push_back({(i == msg.len() - 1), 8'(msg[i])});
      exp_q.push_back(8'(msg[i]));
    end
    first_g = -1; first_v = -1; first_r = -1; k = 0;
    while (out_q.size() < 13 && k < 200) begin
      cycle();
      if (first_g < 0 && grant == 3'b001) first_g = k;
      if (first_r < 0 && req_ready == 3'b001) first_r = k;
      if (first_v < 0 && tx_data_valid) first_v = k;
      k++;
    end
    chk("at_first_grant", first_g, 1);
    chk("at_first_ready", first_r, 1);
    chk("at_first_txv", first_v, 2);
    check_out("at");
    gap_len = 0; k = 0;
    while (busy && k < 50) begin
      cycle();
      if (busy && grant == 3'b000) gap_len++;
      k++;
    end
    chk("at_gap_len", gap_len, 4);
    chk("at_overrun", ov_cnt, 0);
    chk("at_ready_rule", ready_err, 0);

    // Round robin: two rounds of 2-byte packets from all three.
    do_reset();
    for (int rd = 0; rd < 2; rd++) begin
      for (int r = 0; r < 3; r++) begin
        for (int j = 0; j < 2; j++) begin
          pq[r].push_back({(j == 1), 8'(rd * 64 + r * 16 + j)});
          exp_q.push_back(8'(rd * 64 + r * 16 + j));
        end
      end
      run_out(6 * (rd + 1), 300);
      run_idle($sformatf("rr_idle%0d", rd), 50);
    end
    chk("rr_grants", glog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_grant%0d", i), (i < glog.size()) ? {29'd0, glog[i]} : 32'hFFFF_FFFF,
          (i % 3 == 0) ? 32'd1 : ((i % 3 == 1) ? 32'd2 : 32'd4));
    end
    check_out("rr");

    // Non-owner request mid-packet waits for drain and GAP.
    do_reset();
    for (int j = 0; j < 5; j++) begin
      pq[1].push_back({(j == 4), 8'(8'h20 + j)});
      exp_q.push_back(8'(8'h20 + j));
    end
    for (int j = 0; j < 3; j++) exp_q.push_back(8'(8'h30 + j));
    pushed = 0; seen_idle = 0; idle_before = 0; got2 = 0; viol2 = 0; k = 0;
    while (out_q.size() < 8 && k < 300) begin
      cycle();
      k++;
      if (req_ready[2] && grant != 3'b100) viol2++;
      if (pushed && !busy) seen_idle = 1;
      if (!got2 && grant == 3'b100) begin
        got2 = 1;
        idle_before = seen_idle;
      end
      if (!pushed && grant == 3'b010) begin
        for (int j = 0; j < 3; j++) pq[2].push_back({(j == 2), 8'(8'h30 + j)});
        pushed = 1;
      end
    end
    chk("hold_ready2", viol2, 0);
    chk("hold_idle_before_grant2", {31'd0, idle_before}, 32'd1);
    chk("hold_grants", glog.size(), 2);
    chk("hold_second", (glog.size() > 1) ? {29'd0, glog[1]} : 32'hFFFF_FFFF, 32'd4);
    check_out("hold");

    // Output stall of 20 cycles on byte 5.
    do_reset();
    for (int j = 0; j < 10; j++) begin
      pq[0].push_back({(j == 9), 8'(8'hA0 + j)});
      exp_q.push_back(8'(8'hA0 + j));
    end
    stall_at = 4; stall_left = 20;
    run_out(10, 300);
    run_idle("stall_idle", 50);
    chk("stall_cycles", stall_seen, 20);
    chk("stall_stable", stab_err, 0);
    chk("stall_ready", ready_err, 0);
    check_out("stall");

    // Truncation at MAX_BYTES=4, remainder on the next grant.
    use4 = 1'b1;
    do_reset();
    for (int j = 0; j < 6; j++) begin
      pq[0].push_back({1'b0, 8'(8'hC0 + j)});
      exp_q.push_back(8'(8'hC0 + j));
    end
    run_out(6, 300);
    repeat (10) cycle();
    check_out("trunc");
    chk("trunc_overrun", ov_cnt, 1);
    chk("trunc_grants", glog.size(), 2);
    chk("trunc_regrant", (glog.size() > 1) ? {29'd0, glog[1]} : 32'hFFFF_FFFF, 32'd1);
    chk("trunc_held", {28'd0, busy, grant}, {28'd0, 1'b1, 3'b001});
    use4 = 1'b0;

    // Reset mid-packet, then arbitration restarts at index 0.
    do_reset();
    for (int j = 0; j < 10; j++) pq[1].push_back({(j == 9), 8'(8'h50 + j)});
    run_out(3, 100);
    chk("rst_pre_bytes", out_q.size(), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    clear_state();
    @(negedge clk);
    req_valid = '0; req_last = '0; req_data = '0;
    @(negedge clk);
    reset_n = 1'b1;
    pq[0].push_back({1'b1, 8'h77});
    pq[2].push_back({1'b1, 8'h99});
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h99);
    run_out(2, 200);
    run_idle("rst_idle", 50);
    chk("rst_first_grant", (glog.size() > 0) ? {29'd0, glog[0]} : 32'hFFFF_FFFF, 32'd1);
    check_out("rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
